// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared PRBS-8 definitions for the LFSR generator and checker
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // feedback taps at bits 0, 2, 3 and 4
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TRACK,
        LOCKED
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// rtl/edge_rise_det.sv - registered copy of a level input and its rising-edge pulse
module edge_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= 1'b0;
        end else begin
            d_r <= d;
        end
    end

    assign rise = d & ~d_r;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - PRBS-8 receive checker: acquire, lock, count errors, measure period
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_THRESH = 2,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              din_vld,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              period_done,
    output logic [8:0]        period_len
);

    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_THRESH - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);
    localparam logic [8:0]    PER_MAX    = 9'h1FF;

    chk_state_t        state;
    logic [LFSR_W-1:0] ref_q;
    logic [LFSR_W-1:0] lock_val;
    logic [LFSR_W-1:0] exp_w;
    logic [MW-1:0]     match_cnt;
    logic [LW-1:0]     miss_cnt;
    logic [8:0]        per_cnt;
    logic              start_rise;

    edge_rise_det u_start_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start),
        .rise  (start_rise)
    );

    assign exp_w = lfsr_next(ref_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ref_q       <= '0;
            lock_val    <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            per_cnt     <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            period_done <= 1'b0;
            period_len  <= '0;
        end else begin
            err_pulse   <= 1'b0;
            period_done <= 1'b0;
            if (start_rise) begin
                err_cnt   <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
                state     <= ACQ;
            end else if (din_vld) begin
                case (state)
                    ACQ: begin
                        if (din != '0) begin
                            ref_q     <= din;
                            match_cnt <= '0;
                            state     <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (din == exp_w) begin
                            ref_q     <= din;
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt == MATCH_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                lock_val <= din;
                                per_cnt  <= '0;
                                miss_cnt <= '0;
                            end
                        end else if (din != '0) begin
                            ref_q     <= din;
                            match_cnt <= '0;
                        end else begin
                            state <= ACQ;
                        end
                    end
                    LOCKED: begin
                        // flywheel: prediction advances on its own, bad words never reseed it
                        ref_q <= exp_w;
                        if (din == exp_w) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                            miss_cnt <= miss_cnt + LW'(1);
                            if (miss_cnt == MISS_LAST) begin
                                locked <= 1'b0;
                                state  <= ACQ;
                            end
                        end
                        if (exp_w == lock_val) begin
                            period_done <= 1'b1;
                            period_len  <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 9'd1;
                            per_cnt     <= '0;
                        end else if (per_cnt != PER_MAX) begin
                            per_cnt <= per_cnt + 9'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker against a word-level PRBS model
module tb_lfsr_checker;

    localparam int LOCK_THRESH = 2;
    localparam int LOSS_THRESH = 4;
    localparam int ERR_W       = 16;

    typedef struct packed {
        logic              locked;
        logic              err_pulse;
        logic [ERR_W-1:0]  err_cnt;
        logic              period_done;
        logic [8:0]        period_len;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       din;
    logic             din_vld;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             period_done;
    logic [8:0]       period_len;

    lfsr_checker #(
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH),
        .ERR_W       (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .din         (din),
        .din_vld     (din_vld),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
        .period_done (period_done),
        .period_len  (period_len)
    );

    always #5 clk = ~clk;

    exp_t act_w;
    assign act_w = '{locked, err_pulse, err_cnt, period_done, period_len};

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   cyc   = 0;
    int   obs_pd_n = 0;

    // model: word-level view of the link, modes 0 idle, 1 acquiring, 2 tracking, 3 locked
    int         m_mode = 0;
    bit         m_st = 0;
    logic [7:0] m_ref = 0;
    int         m_run = 0;
    int         m_miss = 0;
    int         m_err = 0;
    int         m_since = 0;
    int         m_per = 1;
    int         m_plen = 0;
    bit         m_locked = 0;
    int         m_pd_n = 0;

    logic [7:0] cur, p1, p2;
    int         per_main;
    bit         prev_err;
    bit         st_lvl;

    function automatic logic [7:0] bpred(input logic [7:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[4];
        return (s >> 1) | ({7'd0, fb} << 7);
    endfunction

    function automatic int period_of(input logic [7:0] w);
        logic [7:0] s;
        int n;
        s = w;
        n = 0;
        do begin
            s = bpred(s);
            n++;
        end while (s != w && n < 600);
        return n;
    endfunction

    task automatic model(input bit st, input bit v, input logic [7:0] d, output exp_t e);
        bit rise, pulse, pd;
        logic [7:0] x;
        rise  = st && !m_st;
        m_st  = st;
        pulse = 0;
        pd    = 0;
        if (rise) begin
            m_err = 0; m_locked = 0; m_mode = 1; m_run = 0; m_miss = 0;
        end else if (v) begin
            if (m_mode == 1) begin
                if (d != 0) begin m_ref = d; m_run = 0; m_mode = 2; end
            end else if (m_mode == 2) begin
                if (d == bpred(m_ref)) begin
                    m_ref = d;
                    m_run++;
                    if (m_run == LOCK_THRESH) begin
                        m_mode = 3; m_locked = 1; m_per = period_of(d); m_since = 0; m_miss = 0;
                    end
                end else if (d != 0) begin
                    m_ref = d; m_run = 0;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 3) begin
                x = bpred(m_ref);
                m_ref = x;
                m_since++;
                if (m_since % m_per == 0) begin
                    pd = 1; m_plen = (m_per > 511) ? 511 : m_per; m_pd_n++;
                end
                if (d != x) begin
                    pulse = 1;
                    if (m_err < (1 << ERR_W) - 1) m_err++;
                    m_miss++;
                    if (m_miss == LOSS_THRESH) begin m_locked = 0; m_mode = 1; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        e = '{m_locked, pulse, ERR_W'(m_err), pd, 9'(m_plen)};
    endtask

    task automatic step(input bit st, input bit v, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        start = st; din_vld = v; din = d;
        model(st, v, d, e);
        @(posedge clk);
        sb.push_back(e);
    endtask

    task automatic check_now(input string nm, input exp_t want);
        total++;
        if (act_w !== want) begin
            bad++;
            $display("FAIL %s got lk=%b ep=%b ec=%0d pd=%b pl=%0d want lk=%b ep=%b ec=%0d pd=%b pl=%0d",
                     nm, act_w.locked, act_w.err_pulse, act_w.err_cnt, act_w.period_done, act_w.period_len,
                     want.locked, want.err_pulse, want.err_cnt, want.period_done, want.period_len);
        end
    endtask

    always @(negedge clk) begin
        exp_t w;
        cyc++;
        if (sb.size() > 0) begin
            w = sb.pop_front();
            if (act_w.period_done === 1'b1) obs_pd_n++;
            total++;
            if (act_w !== w) begin
                bad++;
                $display("FAIL outputs cyc=%0d got lk=%b ep=%b ec=%0d pd=%b pl=%0d want lk=%b ep=%b ec=%0d pd=%b pl=%0d",
                         cyc, act_w.locked, act_w.err_pulse, act_w.err_cnt, act_w.period_done, act_w.period_len,
                         w.locked, w.err_pulse, w.err_cnt, w.period_done, w.period_len);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_st = 0; m_ref = 0; m_run = 0; m_miss = 0; m_err = 0;
        m_since = 0; m_plen = 0; m_locked = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; din_vld = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_now("reset", '0);
        rst_n = 1'b1;

        // lock from 0x01
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        // single error in place of 0x20
        step(0, 1, 8'h00);
        step(0, 1, 8'h10);
        step(0, 1, 8'h88);
        step(0, 1, 8'hC4);

        // period measurement with gaps and sparse injected errors
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        per_main = period_of(8'h40);
        cur = 8'h40;
        prev_err = 0;
        for (int i = 0; i < 3 * per_main; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 0, 8'($urandom));
            cur = bpred(cur);
            if (!prev_err && $urandom_range(0, 15) == 0) begin
                step(0, 1, cur ^ 8'h24);
                prev_err = 1;
            end else begin
                step(0, 1, cur);
                prev_err = 0;
            end
        end

        // loss of lock, then relock
        repeat (4) step(0, 1, 8'h55);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 1, 8'h20);

        // acquisition ignores zeros
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);

        // TRACK mismatch reseeds from 0x33; zero in TRACK returns to ACQ
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        p1 = bpred(8'h33);
        p2 = bpred(p1);
        step(0, 1, 8'h33);
        step(0, 1, p1);
        step(0, 1, p2);
        step(0, 1, bpred(p2));

        // start edge beats a mismatching valid word
        step(1, 1, bpred(bpred(p2)) ^ 8'hFF);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 1, 8'h20);

        // random mostly-coherent stream with restarts
        cur = 8'($urandom_range(1, 255));
        st_lvl = 0;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) st_lvl = ~st_lvl;
            if (r < 82) cur = bpred(cur);
            else cur = 8'($urandom);
            step(st_lvl, (r % 5) != 0, cur);
        end

        // async reset mid-stream
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 1, 8'h20);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 1, 8'h20);
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h80);
        step(0, 1, 8'h40);
        step(0, 0, 8'h00);

        drain();
        total++;
        if (obs_pd_n != m_pd_n) begin
            bad++;
            $display("FAIL period_count got=%0d want=%0d", obs_pd_n, m_pd_n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
